// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the CPU.
// Fetch-state enum, opcode constants and default widths.
package cpu_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 32;

    localparam logic [CPU_DATA_W-1:0] NOP  = 32'h0;
    localparam logic [5:0]            OP_J = 6'h02;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, hazard/redirect
// controls and the IF/ID outputs presented to decode.
interface if_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_data;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc4;
    logic              halted;
    logic [CNT_W-1:0]  fetch_cnt;

    modport master (
        output im_addr,
        input  im_data,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_pc4,
        output halted,
        output fetch_cnt
    );

    modport slave (
        input  im_addr,
        output im_data,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_pc4,
        input  halted,
        input  fetch_cnt
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush.
// Flush inserts a nop bubble; hold is simply no load.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] instr_d,
    input  logic [ADDR_W-1:0] pc_d,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4
);

    // Capture fetched word, bubble on flush, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP;
            pc    <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_d;
            pc    <= pc_d;
            pc4   <= pc_d + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, fetch FSM and fetch counter.
// Optional self-jump halt detection: define IF_HALT_DETECT_EN.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input logic            clk,
    input logic            rst_n,
    if_fetch_unit_if.master bus
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              load;
    logic              flush;
    logic              cnt_inc;

`ifdef IF_HALT_DETECT_EN
    logic self_jump;

    assign self_jump = bus.id_valid
        && (bus.id_instr[31:26] == OP_J)
        && ({bus.id_instr[ADDR_W-3:0], 2'b00} == bus.id_pc);
    assign bus.halted = (state_q == HALT);
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.im_addr   = pc_q;
    assign bus.fetch_cnt = cnt_q;

    // Next PC / state: redirect beats stall beats fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        cnt_inc = 1'b0;
`ifdef IF_HALT_DETECT_EN
        if (state_q == HALT) begin
            flush = 1'b1;
        end else if (self_jump) begin
            state_d = HALT;
            pc_d    = bus.id_pc;
            flush   = 1'b1;
        end else
`endif
        if (bus.redirect_valid) begin
            pc_d    = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            flush   = 1'b1;
            state_d = RUN;
        end else if (bus.stall) begin
            state_d = HOLD;
        end else begin
            load    = 1'b1;
            pc_d    = pc_q + ADDR_W'(4);
            cnt_inc = 1'b1;
            state_d = RUN;
        end
    end

    // PC and fetch state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // Saturating count of words delivered valid into IF/ID.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .flush   (flush),
        .instr_d (bus.im_data),
        .pc_d    (pc_q),
        .valid   (bus.id_valid),
        .instr   (bus.id_instr),
        .pc      (bus.id_pc),
        .pc4     (bus.id_pc4)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed plan plus
// random stall/redirect/reset against a reference model.
module tb_if_fetch_unit;

    localparam int CNT_W = 4;

    typedef struct {
        logic [7:0]       im_addr;
        logic             id_valid;
        logic [31:0]      id_instr;
        logic [7:0]       id_pc;
        logic [7:0]       id_pc4;
        logic             halted;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] mem [64];

    int vectors = 0;
    int errors  = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [7:0]       m_pc;
    logic             m_v;
    logic [31:0]      m_instr;
    logic [7:0]       m_idpc;
    logic [7:0]       m_idpc4;
    logic             m_halt;
    logic [CNT_W-1:0] m_cnt;

    if_fetch_unit_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(CNT_W)) bus ();

    if_fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .RESET_PC (8'h00),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.im_data = mem[bus.im_addr[7:2]];

    function automatic bit halt_en();
`ifdef IF_HALT_DETECT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model(input logic r, input logic s,
                         input logic rv, input logic [7:0] rp);
        logic [7:0] tgt;
        tgt = {m_instr[5:0], 2'b00};
        if (!r) begin
            m_pc = 8'h00; m_v = 0; m_instr = 0;
            m_idpc = 0; m_idpc4 = 0; m_halt = 0; m_cnt = 0;
        end else if (m_halt) begin
            m_v = 0; m_instr = 0;
        end else if (halt_en() && m_v && m_instr[31:26] == 6'h02
                     && tgt == m_idpc) begin
            m_halt = 1; m_pc = m_idpc; m_v = 0; m_instr = 0;
        end else if (rv) begin
            m_pc = rp & 8'hFC; m_v = 0; m_instr = 0;
        end else if (!s) begin
            m_instr = mem[m_pc / 4];
            m_idpc  = m_pc;
            m_idpc4 = m_pc + 8'd4;
            m_v     = 1;
            m_pc    = m_pc + 8'd4;
            if (int'(m_cnt) < (1 << CNT_W) - 1) m_cnt = m_cnt + 1'b1;
        end
    endtask

    // Drive one cycle at negedge, push model result, wait one cycle.
    task automatic cyc(input logic r, input logic s,
                       input logic rv, input logic [7:0] rp);
        exp_t e;
        rst_n = r;
        bus.stall = s;
        bus.redirect_valid = rv;
        bus.redirect_pc = rp;
        model(r, s, rv, rp);
        e.im_addr = m_pc;
        e.id_valid = m_v;
        e.id_instr = m_instr;
        e.id_pc = m_idpc;
        e.id_pc4 = m_idpc4;
        e.halted = m_halt;
        e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if (bus.im_addr !== e.im_addr || bus.id_valid !== e.id_valid
                    || bus.id_instr !== e.id_instr || bus.id_pc !== e.id_pc
                    || bus.id_pc4 !== e.id_pc4 || bus.halted !== e.halted
                    || bus.fetch_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL sb t=%0t: got a=%h v=%b i=%h pc=%h pc4=%h h=%b c=%0d want a=%h v=%b i=%h pc=%h pc4=%h h=%b c=%0d",
                        $time, bus.im_addr, bus.id_valid, bus.id_instr,
                        bus.id_pc, bus.id_pc4, bus.halted, bus.fetch_cnt,
                        e.im_addr, e.id_valid, e.id_instr, e.id_pc,
                        e.id_pc4, e.halted, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == 6'h02) mem[i][31:26] = 6'h03;
        end
        mem[0]        = 32'h3c09abcd;
        mem[1]        = 32'h1d20000a;
        mem[2]        = 32'h00000000;
        mem[8'h44/4]  = 32'h2008ffff;
        mem[8'hE4/4]  = 32'h08000c39;
        mem[8'hFC/4]  = 32'h00000000;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        m_pc = 0; m_v = 0; m_instr = 0; m_idpc = 0;
        m_idpc4 = 0; m_halt = 0; m_cnt = 0;
        @(negedge clk);

        cyc(0, 0, 0, 8'h00);
        chk("rst_addr", 32'(bus.im_addr), 32'h00);
        chk("rst_valid", 32'(bus.id_valid), 32'h0);
        chk("rst_cnt", 32'(bus.fetch_cnt), 32'h0);
        cyc(1, 0, 0, 8'h00);
        chk("f1_instr", bus.id_instr, 32'h3c09abcd);
        chk("f1_pc", 32'(bus.id_pc), 32'h00);
        chk("f1_pc4", 32'(bus.id_pc4), 32'h04);
        chk("f1_addr", 32'(bus.im_addr), 32'h04);
        cyc(1, 0, 0, 8'h00);
        chk("f2_instr", bus.id_instr, 32'h1d20000a);
        chk("f2_cnt", 32'(bus.fetch_cnt), 32'h2);
        chk("f2_addr", 32'(bus.im_addr), 32'h08);
        cyc(1, 1, 0, 8'h00);
        cyc(1, 1, 0, 8'h00);
        chk("st_addr", 32'(bus.im_addr), 32'h08);
        chk("st_instr", bus.id_instr, 32'h1d20000a);
        chk("st_cnt", 32'(bus.fetch_cnt), 32'h2);
        cyc(1, 0, 0, 8'h00);
        chk("rel_instr", bus.id_instr, 32'h0);
        chk("rel_pc", 32'(bus.id_pc), 32'h08);
        chk("rel_valid", 32'(bus.id_valid), 32'h1);
        cyc(1, 1, 1, 8'h46);
        chk("rd_addr", 32'(bus.im_addr), 32'h44);
        chk("rd_valid", 32'(bus.id_valid), 32'h0);
        cyc(1, 0, 0, 8'h00);
        chk("rd_instr", bus.id_instr, 32'h2008ffff);
        chk("rd_pc", 32'(bus.id_pc), 32'h44);
        cyc(1, 0, 1, 8'hFC);
        cyc(1, 0, 0, 8'h00);
        chk("wr_pc", 32'(bus.id_pc), 32'hFC);
        chk("wr_pc4", 32'(bus.id_pc4), 32'h00);
        chk("wr_addr", 32'(bus.im_addr), 32'h00);
        cyc(1, 0, 0, 8'h00);
        chk("wr_instr", bus.id_instr, 32'h3c09abcd);
        cyc(1, 0, 1, 8'hE4);
        cyc(1, 0, 0, 8'h00);
        chk("sj_instr", bus.id_instr, 32'h08000c39);
        chk("sj_pc", 32'(bus.id_pc), 32'hE4);
        cyc(1, 0, 0, 8'h00);
        chk("sj_halted", 32'(bus.halted), halt_en() ? 32'h1 : 32'h0);
        chk("sj_addr", 32'(bus.im_addr), halt_en() ? 32'hE4 : 32'hEC);
        cyc(1, 0, 1, 8'h00);
        chk("sj_rd", 32'(bus.im_addr), halt_en() ? 32'hE4 : 32'h00);
        cyc(0, 0, 0, 8'h00);
        chk("sj_rst", 32'(bus.halted), 32'h0);

        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0),
                8'($urandom));
        end
        cyc(1, 0, 0, 8'h00);

        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the five-stage pipeline CPU; drives the 8-bit byte address into the combinational instruction memory and captures the returned 32-bit word.
- Owns the PC register and the IF/ID pipeline register.
- Takes stall requests from the hazard unit and PC redirects (branch/jump/jr) from later stages.
- Presents valid instruction/PC pairs to the decode stage.

Parameters:
- ADDR_W, 8, instruction byte-address width (matches IM address port)
- DATA_W, 32, instruction word width
- RESET_PC, 8'h00, PC value loaded on reset
- CNT_W, 16, width of fetch performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous active-low reset
- im_addr  out  ADDR_W  byte address to instruction memory (= pc register, word aligned)
- im_data  in  DATA_W  instruction word from memory, combinational response to im_addr
- stall  in  1  hazard unit: hold PC and IF/ID contents
- redirect_valid  in  1  later stage requests PC change this cycle
- redirect_pc  in  ADDR_W  target byte address for redirect
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  DATA_W  IF/ID instruction (32'h0 = nop when invalid)
- id_pc  out  ADDR_W  address of id_instr
- id_pc4  out  ADDR_W  id_pc + 4, modulo 2^ADDR_W
- halted  out  1  fetch frozen (only driven high with optional feature, else constant 0)
- fetch_cnt  out  CNT_W  count of instructions delivered valid into IF/ID

Behaviour:
- All state updates on the rising clk edge; rst_n is sampled there only. Reset is synchronous and active-low.
- Reset values: pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc4=0, halted=0, fetch_cnt=0, state=RUN.
- im_addr is the pc register directly. IM latency is zero (same-cycle im_data). Fetch-to-decode latency is 1 cycle.
- States:
  - RUN: normal fetch.
  - HOLD: stall asserted.
  - HALT: optional feature only.
- Per-cycle priority, highest first: reset > redirect_valid > stall > normal fetch.
- redirect_valid=1, any state except HALT:
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}; misaligned low bits are forced to 0.
  - id_valid <= 0, id_instr <= 0 (one bubble).
  - state <= RUN. This applies even if stall=1 in the same cycle.
- stall=1, no redirect: pc and all IF/ID registers hold; state <= HOLD; fetch_cnt holds.
- Normal fetch (RUN, or HOLD with stall deasserted):
  - id_instr <= im_data, id_pc <= pc, id_pc4 <= pc+4, id_valid <= 1.
  - pc <= pc+4, wrapping 0xFC -> 0x00.
  - fetch_cnt++, saturating at all-ones.
- Address is not range-checked; IM returns 0 (nop) for unmapped addresses and the word is delivered valid.
- Reset asserted mid-stall or mid-redirect: reset wins and all outputs take reset values on that edge.

Optional Feature:
- Macro IF_HALT_DETECT_EN.
- Defined:
  - When the IF/ID register holds a valid J instruction (id_instr[31:26]==6'h02) whose target {id_instr[ADDR_W-3:0],2'b00} equals id_pc, enter HALT on the next edge.
  - In HALT: halted=1, pc frozen at id_pc, id_valid <= 0, fetch_cnt frozen.
  - Only reset exits HALT; redirects are ignored while halted.
- Not defined: no HALT state, halted tied 0, a self-jump simply refetches via redirect.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W/DATA_W defaults and the NOP word 32'h0.
  - Opcode constant OP_J=6'h02.
  - Fetch state enum {RUN, HOLD, HALT}.
- One natural sub-module, if_id_reg: the IF/ID register with valid, hold and flush controls. The top holds the PC/state logic and the counter.

Test Plan:
- Reset then 3 free-running cycles with standard IM image: im_addr 0x00,0x04,0x08; id_instr 0x3c09abcd then 0x1d20000a; id_pc 0x00, id_pc4 0x04; fetch_cnt=2 after cycle 2.
- stall high 2 cycles at pc=0x08: im_addr stays 0x08, id_instr stays 0x1d20000a, fetch_cnt unchanged. On release, id_instr=0x00000000 (word at 0x08), id_pc=0x08.
- redirect_valid with redirect_pc=0x46 and stall=1 simultaneously: next cycle im_addr=0x44, id_valid=0. Following cycle id_instr=0x2008ffff, id_pc=0x44.
- Force pc to 0xFC by redirect: next fetch gives id_pc=0xFC, id_pc4=0x00, im_addr=0x00, instruction 0x3c09abcd delivered.
- With IF_HALT_DETECT_EN, redirect to 0xE4 (0x08000c39 self-jump):
  - After the word reaches IF/ID with id_pc=0xE4, halted=1 next cycle; pc frozen.
  - A later redirect to 0x00 is ignored.
  - rst_n=0 clears halted.
- Without the macro, the same sequence: halted stays 0, fetch continues to 0xE8.
